// File: rtl/mem_pkg.sv
// Shared widths, state encoding and default abort limit for the memory master.
package mem_pkg;

  localparam int ADDR_W      = 12;
  localparam int DATA_W      = 16;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_IDLE   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_GAP    = 2'd3
  } state_t;

endpackage

// File: rtl/mem_master.sv
// Single-access memory master: one requester transaction at a time on a shared
// tri-state data bus, with a bounded wait for the memory acknowledge.
module mem_master
  import mem_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              done,
  output logic              err,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] maddr,
  inout  wire  [DATA_W-1:0] mdata,
  output logic              mrdwr,
  output logic              men,
  input  logic              mack
);

  localparam logic [3:0] TO_LAST = 4'(TIMEOUT - 1);
  localparam logic [3:0] TO_LIM  = 4'(TIMEOUT);

  state_t              state_q, state_d;
  logic                init_q, init_d;
  logic [3:0]          tcnt_q, tcnt_d;
  logic                men_d, mrdwr_d, done_d, err_d;
  logic [ADDR_W-1:0]   maddr_d;
  logic [DATA_W-1:0]   rdata_d;
  logic [DATA_W-1:0]   wreg_q;
  logic                wreg_ld;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_INIT;
      init_q  <= 1'b0;
      tcnt_q  <= '0;
      men     <= 1'b0;
      mrdwr   <= 1'b0;
      maddr   <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      rdata   <= '0;
    end else begin
      state_q <= state_d;
      init_q  <= init_d;
      tcnt_q  <= tcnt_d;
      men     <= men_d;
      mrdwr   <= mrdwr_d;
      maddr   <= maddr_d;
      done    <= done_d;
      err     <= err_d;
      rdata   <= rdata_d;
    end
  end

  // Write data is pure datapath; it is only observed while an access is active.
  always_ff @(posedge clock) begin
    if (wreg_ld) wreg_q <= wdata;
  end

  always_comb begin
    state_d = state_q;
    init_d  = init_q;
    tcnt_d  = tcnt_q;
    men_d   = men;
    mrdwr_d = mrdwr;
    maddr_d = maddr;
    rdata_d = rdata;
    done_d  = 1'b0;
    err_d   = 1'b0;
    wreg_ld = 1'b0;
    unique case (state_q)
      ST_INIT: begin
        // Two quiet cycles let the memory float the bus and drop any stale ack.
        men_d = 1'b0;
        if (init_q) state_d = ST_IDLE;
        else        init_d  = 1'b1;
      end
      ST_IDLE: begin
        if (req) begin
          maddr_d = addr;
          mrdwr_d = we;
          wreg_ld = 1'b1;
          men_d   = 1'b1;
          tcnt_d  = '0;
          state_d = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        // An ack on the limit edge still counts as success.
        if (mack) begin
          if (!mrdwr) rdata_d = mdata;
          done_d  = 1'b1;
          men_d   = 1'b0;
          state_d = ST_GAP;
        end else if (tcnt_q == TO_LAST) begin
          tcnt_d  = TO_LIM;
          done_d  = 1'b1;
          err_d   = 1'b1;
          men_d   = 1'b0;
          state_d = ST_GAP;
        end else begin
          tcnt_d = tcnt_q + 4'd1;
        end
      end
      ST_GAP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  assign ready = (state_q == ST_IDLE);
  assign mdata = (state_q == ST_ACCESS && mrdwr) ? wreg_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_mem_master.sv
// Directed bench for mem_master with a registered-ack memory model and a
// queue-based scoreboard checked whenever done pulses.
module tb_mem_master;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req;
  logic        we;
  logic [11:0] addr;
  logic [15:0] wdata;
  logic        ready, done, err, mrdwr, men;
  logic [15:0] rdata;
  logic [11:0] maddr;
  wire  [15:0] mdata;
  logic        mack;

  mem_master dut (
    .clock(clock), .reset_n(reset_n), .req(req), .we(we), .addr(addr),
    .wdata(wdata), .ready(ready), .done(done), .err(err), .rdata(rdata),
    .maddr(maddr), .mdata(mdata), .mrdwr(mrdwr), .men(men), .mack(mack)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ack and read data registered one edge after sampling men=1.
  logic [15:0] mem [0:4095];
  logic        mem_drv = 1'b0;
  logic [15:0] mem_q;
  int          men_cnt = 0;
  int          men_nxt;
  bit          noack = 1'b0;
  int          ack_need = 1;

  assign mdata = mem_drv ? mem_q : 16'bz;

  always @(posedge clock) begin
    men_nxt = men ? men_cnt + 1 : 0;
    men_cnt <= men_nxt;
    mack    <= men && !noack && (men_nxt >= ack_need);
    mem_drv <= men && !mrdwr;
    mem_q   <= mem[maddr];
    if (men && mrdwr) mem[maddr] <= mdata;
  end

  typedef struct {
    logic        err;
    logic [15:0] rd;
    int          lat;
  } exp_t;

  exp_t expq[$];
  int   accq[$];
  int   men_run = 0;
  int   men_last = 0;
  bit   men_low_seen = 1'b0;
  int   conflicts = 0;

  always @(negedge clock) begin
    exp_t e;
    int   a;
    if (men) men_run++;
    else begin
      if (men_run != 0) men_last = men_run;
      men_run = 0;
      men_low_seen = 1'b1;
    end
    if (mem_drv && men && mrdwr) conflicts++;
    if (done) begin
      if (expq.size() == 0 || accq.size() == 0) begin
        chk("unexpected_done", 32'(done), 32'd0);
      end else begin
        e = expq.pop_front();
        a = accq.pop_front();
        chk("done_err", 32'(err), 32'(e.err));
        chk("done_rdata", 32'(rdata), 32'(e.rd));
        chk("done_latency", 32'(cyc - a), 32'(e.lat));
        chk("men_after_done", 32'(men), 32'd0);
      end
    end else if (err) begin
      chk("err_without_done", 32'(err), 32'd0);
    end
  end

  int last_acc;

  task automatic issue(input logic w, input logic [11:0] a, input logic [15:0] d,
                       input logic e_err, input logic [15:0] e_rd, input int lat,
                       input bit expect_done);
    bit   got;
    exp_t e;
    req = 1'b1; we = w; addr = a; wdata = d;
    if (expect_done) begin
      e.err = e_err; e.rd = e_rd; e.lat = lat;
      expq.push_back(e);
    end
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clock);
      if (ready) got = 1'b1;
    end
    if (!got) chk("accept_timeout", 32'(ready), 32'd1);
    last_acc = cyc + 1;
    if (expect_done && got) accq.push_back(last_acc);
    @(posedge clock); #1;
  endtask

  task automatic wait_idle();
    bit empty;
    req = 1'b0;
    empty = 1'b0;
    for (int i = 0; i < 60 && !empty; i++) begin
      @(negedge clock);
      if (expq.size() == 0) empty = 1'b1;
    end
    if (!empty) chk("done_wait_timeout", 32'(expq.size()), 32'd0);
    repeat (2) @(posedge clock);
    #1;
  endtask

  int first_acc;

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
    mem[12'h005] = 16'hBEEF;
    mem[12'h001] = 16'h0111;
    mem[12'h0AB] = 16'hCAFE;
    reset_n = 1'b0; req = 1'b0; we = 1'b0; addr = '0; wdata = '0;

    repeat (3) @(posedge clock);
    #1;
    chk("rst_men", 32'(men), 32'd0);
    chk("rst_mrdwr", 32'(mrdwr), 32'd0);
    chk("rst_maddr", 32'(maddr), 32'd0);
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset_n = 1'b1;
    @(negedge clock); chk("init_ready0", 32'(ready), 32'd0);
    @(negedge clock); chk("init_ready1", 32'(ready), 32'd0);
    @(negedge clock); chk("init_ready2", 32'(ready), 32'd1);
    @(posedge clock); #1;

    // Plain read
    issue(1'b0, 12'h005, 16'h0000, 1'b0, 16'hBEEF, 2, 1'b1);
    wait_idle();
    chk("read_men_cycles", 32'(men_last), 32'd2);

    // Write to the top address, then read it back
    issue(1'b1, 12'hFFF, 16'h1234, 1'b0, 16'hBEEF, 2, 1'b1);
    wait_idle();
    chk("write_mem_fff", 32'(mem[12'hFFF]), 32'h1234);
    chk("write_men_cycles", 32'(men_last), 32'd2);
    issue(1'b0, 12'hFFF, 16'h0000, 1'b0, 16'h1234, 2, 1'b1);
    wait_idle();

    // Back-to-back with req held high
    issue(1'b0, 12'h001, 16'h0000, 1'b0, 16'h0111, 2, 1'b1);
    first_acc = last_acc;
    men_low_seen = 1'b0;
    issue(1'b1, 12'h002, 16'h2222, 1'b0, 16'h0111, 2, 1'b1);
    chk("b2b_spacing", 32'(last_acc - first_acc), 32'd4);
    chk("b2b_men_low", 32'(men_low_seen), 32'd1);
    wait_idle();

    // Memory never acks: abort after the limit, rdata untouched
    noack = 1'b1;
    issue(1'b0, 12'h005, 16'h0000, 1'b1, 16'h0111, 15, 1'b1);
    wait_idle();
    noack = 1'b0;

    // Ack sampled exactly on the limit edge wins
    ack_need = 14;
    issue(1'b0, 12'h0AB, 16'h0000, 1'b0, 16'hCAFE, 15, 1'b1);
    wait_idle();

    // Ack one edge too late: abort
    ack_need = 15;
    issue(1'b0, 12'h005, 16'h0000, 1'b1, 16'hCAFE, 15, 1'b1);
    wait_idle();
    ack_need = 1;

    // Reset one cycle into a write: no done, bus released, fresh INIT
    issue(1'b1, 12'h0C3, 16'hA5A5, 1'b0, 16'h0000, 0, 1'b0);
    req = 1'b0;
    chk("mid_bus_driven", 32'(mdata), 32'hA5A5);
    @(posedge clock); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_men", 32'(men), 32'd0);
    chk("mid_rst_bus_released", 32'(mdata == 16'hA5A5), 32'd0);
    chk("mid_rst_ready", 32'(ready), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock); chk("post_rst_ready0", 32'(ready), 32'd0);
    @(negedge clock); chk("post_rst_ready1", 32'(ready), 32'd0);
    @(negedge clock); chk("post_rst_ready2", 32'(ready), 32'd1);
    chk("post_rst_rdata", 32'(rdata), 32'd0);
    @(posedge clock); #1;

    // Confirm the back-to-back write landed
    issue(1'b0, 12'h002, 16'h0000, 1'b0, 16'h2222, 2, 1'b1);
    wait_idle();

    chk("bus_conflicts", 32'(conflicts), 32'd0);
    chk("scoreboard_drained", 32'(expq.size() + accq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 Parameter TIMEOUT, 15, cycles (4-bit range) men may stay high without mack before the access is aborted.
REQ-002 One clock; reset is asynchronous and active-low.
REQ-003 clock  in  1  rising-edge system clock.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 req  in  1  requester access strobe; sampled only while ready=1.
REQ-006 we  in  1  1 = write, 0 = read; sampled with req.
REQ-007 addr  in  12  requester word address; sampled with req.
REQ-008 wdata  in  16  requester write data; sampled with req.
REQ-009 ready  out  1  high in IDLE only; an access is accepted on the edge where req=1 and ready=1.
REQ-010 done  out  1  one-cycle pulse at access completion, success or abort.
REQ-011 err  out  1  one-cycle pulse coincident with done when the access timed out.
REQ-012 rdata  out  16  last successfully read word; held until the next successful read.
REQ-013 maddr  out  12  memory address, registered.
REQ-014 mdata  inout  16  shared memory data bus; master drives only during write accesses, else high-Z.
REQ-015 mrdwr  out  1  1 = write, 0 = read, registered.
REQ-016 men  out  1  memory enable, registered.
REQ-017 mack  in  1  memory acknowledge; registered on the memory side, high one edge after the memory samples men=1.

Function
REQ-018 States: INIT, IDLE, ACCESS, GAP.
REQ-019 INIT: men=0 for exactly 2 cycles after reset release so the memory floats mdata and clears mack; then go to IDLE.
REQ-020 IDLE: ready=1; on req, latch addr/we/wdata into maddr/mrdwr/write register, set men=1, go to ACCESS.
REQ-021 Accept at edge A: men=1 after A; memory samples at A+1; master samples mack=1 at A+2.
REQ-022 On mack=1 in ACCESS: capture mdata into rdata (reads only), pulse done, set men=0, go to GAP.
REQ-023 Nominal latency is 2 cycles from acceptance to done; done is high for the cycle after A+2.
REQ-024 The memory sees men=1 on two edges (A+1, A+2); both are the same idempotent access, and the write data is held valid across both.
REQ-025 mdata is driven with the write register iff state=ACCESS and mrdwr=1; otherwise high-Z.
REQ-026 GAP lasts exactly 1 cycle with men=0, then goes to IDLE.
- Purpose: the memory releases the bus and clears mack before the next access.
- No stale mack is ever sampled, and no read-to-write bus contention occurs.
REQ-027 Throughput: one access per 4 cycles minimum (accept A, next accept A+4).
REQ-028 Timeout counter:
- Cleared on entry to ACCESS; increments each ACCESS cycle with mack=0.
- On reaching TIMEOUT: pulse done and err, set men=0, leave rdata unchanged, go to GAP.
REQ-029 If mack=1 on the same edge the counter reaches TIMEOUT, mack wins: success, err=0.
REQ-030 req while ready=0 is ignored, not queued; the requester holds req until accepted.
REQ-031 maddr and mrdwr hold their last values outside ACCESS.
REQ-032 Address wrap: no address arithmetic; 12'hFFF is an ordinary address.

Reset
REQ-033 While reset_n=0, outputs are: men=0, mrdwr=0, maddr=0, mdata high-Z, ready=0, done=0, err=0, rdata=0, timeout counter=0, state INIT.
REQ-034 Reset asserted mid-access immediately drops men and releases mdata; the access is lost with no done pulse.

Structure
REQ-035 Shared package mem_pkg holds ADDR_W=12, DATA_W=16, the state encoding, and the default TIMEOUT.
REQ-036 Single module; no sub-module is natural (the FSM and 4-bit counter stay inline).

Verification
REQ-037 Read: memory word 0x005=16'hBEEF, req read addr 0x005 -> men high for 2 cycles, done 2 cycles after accept, rdata=16'hBEEF, err=0.
REQ-038 Write then read: write 16'h1234 to 0xFFF, then read 0xFFF -> rdata=16'h1234; mdata never driven by both sides in any cycle (no X on bus).
REQ-039 Back-to-back: req held high for read 0x001 then write 0x002 -> second accept exactly 4 cycles after first; men low at least 1 cycle between accesses.
REQ-040 Timeout: memory model never acks -> done=1 and err=1 after 15 ACCESS cycles, men=0, rdata unchanged.
REQ-041 Reset mid-access: reset_n low one cycle after accept -> men=0 and mdata=Z immediately; after release ready=0 for 2 cycles, then 1; no done pulse.
REQ-042 Ack at limit: mack arrives on the TIMEOUT edge -> done=1, err=0, rdata updated.
